// File: rtl/fpadd_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpadd_issue
// Purpose  : Operand-issue and result-retire stage wrapped around a pipelined
//            single-precision adder (fpadd) with a fixed latency of LAT edges.
//            Operand pairs are queued in a DEPTH-entry FIFO and issued to the
//            adder at most one per cycle. A LAT-deep tag pipe follows each pair
//            through the adder. Retired results are kept in order in an
//            RBUF-entry buffer. Pairs with a zero or denormal operand bypass
//            the adder result, because the adder forces the hidden bit to 1.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid/in_ready     - operand handshake (ready = FIFO not full)
//            in_a, in_b            - IEEE-754 single operands
//            op_a, op_b            - registered operands to the adder
//            res_in                - adder output
//            out_valid/out_ready   - result handshake (valid = buffer not empty)
//            out_data              - head of the result buffer
//            inflight              - tags in the pipe plus buffered results
// Revision : 1.0 - initial release
// ============================================================================
module fpadd_issue #(
  parameter int DEPTH = 4,  // operand FIFO entries, power of 2, >= 2
  parameter int LAT   = 5,  // adder latency in edges, >= 1
  parameter int RBUF  = 8   // result buffer entries, power of 2, >= LAT and >= 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  output logic [31:0]            op_a,
  output logic [31:0]            op_b,
  input  logic [31:0]            res_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [$clog2(RBUF):0]  inflight
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RBUF);
  localparam int IW = RW + 1;

  // Operand FIFO; pointers carry one wrap bit so full and empty differ.
  logic [31:0]   fa_q [DEPTH];
  logic [31:0]   fa_d [DEPTH];
  logic [31:0]   fb_q [DEPTH];
  logic [31:0]   fb_d [DEPTH];
  logic [AW:0]   fwr_q, fwr_d, frd_q, frd_d;

  logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d;

  // Tag pipe: valid, bypass flag and bypass value per stage.
  logic [LAT-1:0] tv_q, tv_d, tbyp_q, tbyp_d;
  logic [31:0]    tval_q [LAT];
  logic [31:0]    tval_d [LAT];

  // Result buffer.
  logic [31:0]   rb_q [RBUF];
  logic [31:0]   rb_d [RBUF];
  logic [RW:0]   rwr_q, rwr_d, rrd_q, rrd_d;

  logic [IW-1:0] inflight_q, inflight_d;

  logic          fifo_empty, fifo_full;
  logic          push, issue, pop;
  logic [31:0]   head_a, head_b;
  logic          a_zero, b_zero, byp_hit;
  logic [31:0]   byp_val;

  assign fifo_empty = (fwr_q == frd_q);
  assign fifo_full  = (fwr_q[AW] != frd_q[AW]) && (fwr_q[AW-1:0] == frd_q[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  // Credit check uses only the registered count, so a same-cycle pop does
  // not free a slot until the following edge.
  assign issue      = !fifo_empty && (inflight_q < IW'(RBUF));
  assign out_valid  = (rwr_q != rrd_q);
  assign pop        = out_valid && out_ready;
  assign out_data   = rb_q[rrd_q[RW-1:0]];
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign inflight   = inflight_q;

  assign head_a     = fa_q[frd_q[AW-1:0]];
  assign head_b     = fb_q[frd_q[AW-1:0]];

  // Exponent zero covers both true zeros and denormals (flushed to zero).
  assign a_zero     = (head_a[30:23] == 8'd0);
  assign b_zero     = (head_b[30:23] == 8'd0);
  assign byp_hit    = a_zero || b_zero;

  always_comb begin
    byp_val = head_a;
    if (a_zero && b_zero) begin
      byp_val = {head_a[31] & head_b[31], 31'd0};
    end else if (a_zero) begin
      byp_val = head_b;
    end
  end

  always_comb begin
    fa_d       = fa_q;
    fb_d       = fb_q;
    fwr_d      = fwr_q;
    frd_d      = frd_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    tv_d       = '0;
    tbyp_d     = '0;
    tval_d     = tval_q;
    rb_d       = rb_q;
    rwr_d      = rwr_q;
    rrd_d      = rrd_q;
    inflight_d = inflight_q;

    if (push) begin
      fa_d[fwr_q[AW-1:0]] = in_a;
      fb_d[fwr_q[AW-1:0]] = in_b;
      fwr_d               = fwr_q + (AW+1)'(1);
    end

    if (issue) begin
      frd_d  = frd_q + (AW+1)'(1);
      op_a_d = head_a;
      op_b_d = head_b;
    end

    // Tags advance every edge; the adder is never stalled.
    tv_d[0]   = issue;
    tbyp_d[0] = issue && byp_hit;
    tval_d[0] = byp_val;
    for (int i = 1; i < LAT; i++) begin
      tv_d[i]   = tv_q[i-1];
      tbyp_d[i] = tbyp_q[i-1];
      tval_d[i] = tval_q[i-1];
    end

    // res_in belongs to the pair in the last tag stage at this edge.
    if (tv_q[LAT-1]) begin
      rb_d[rwr_q[RW-1:0]] = tbyp_q[LAT-1] ? tval_q[LAT-1] : res_in;
      rwr_d               = rwr_q + (RW+1)'(1);
    end

    if (pop) begin
      rrd_d = rrd_q + (RW+1)'(1);
    end

    if (issue && !pop) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!issue && pop) begin
      inflight_d = inflight_q - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fa_q[i] <= '0;
        fb_q[i] <= '0;
      end
      fwr_q  <= '0;
      frd_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      tv_q   <= '0;
      tbyp_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tval_q[i] <= '0;
      end
      for (int i = 0; i < RBUF; i++) begin
        rb_q[i] <= '0;
      end
      rwr_q      <= '0;
      rrd_q      <= '0;
      inflight_q <= '0;
    end else begin
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      fwr_q      <= fwr_d;
      frd_q      <= frd_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      tv_q       <= tv_d;
      tbyp_q     <= tbyp_d;
      tval_q     <= tval_d;
      rb_q       <= rb_d;
      rwr_q      <= rwr_d;
      rrd_q      <= rrd_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
`default_nettype wire
